// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg
//   Shared types and constants for the boot loader controller:
//   - state_t        : controller FSM states
//   - MAGIC_BYTE     : frame start marker
//   - CHECKSUM_WIDTH : width of the wrap-around frame checksum
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    localparam logic [7:0] MAGIC_BYTE     = 8'hA5;
    localparam int         CHECKSUM_WIDTH = 8;

endpackage

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer
//   Collects bytes, least significant first, into a 32-bit word.
//   Ports:
//     clk           rising-edge clock
//     reset         synchronous active-low reset
//     clear         restart packing at byte 0 (start of a new frame)
//     byte_strobe   a byte is presented on byte_data this cycle
//     byte_data     stream byte
//     word          assembled word; valid while word_complete is high
//     word_complete high on the strobe that carries the 4th byte of a word
module byte_to_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    // Only the first three bytes need storage: the 4th is taken straight
    // from byte_data so the word is available in the same cycle.
    logic [23:0] shift_q;
    logic [1:0]  count_q;

    assign word          = {byte_data, shift_q};
    assign word_complete = byte_strobe && (count_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_strobe) begin
            shift_q <= {byte_data, shift_q[23:8]};
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/boot_loader_controller.sv
// boot_loader_controller
//   Receives a framed byte stream (A5, N, 4*N data bytes, checksum), writes
//   the packed little-endian words to program memory and holds the core in
//   reset until a frame completes with a valid checksum.
//   Ports:
//     clk, reset        clock, synchronous active-low reset
//     byte_valid_i/byte_i/byte_ready_o  byte stream handshake
//     load_req_i        pulse in S_RUN to start a new load
//     core_reset_o      active-low core reset, released only in S_RUN
//     pm_write_o/pm_address_o/pm_data_o  program memory write port
//     load_done_o       high in S_RUN
//     load_error_o      sticky frame error, cleared by the next magic byte
//     state_dbg         current FSM state, for observation only
//
//   Handshake: a byte transfers on a rising edge where byte_valid_i and
//   byte_ready_o are both 1; byte_ready_o depends on state only, never on
//   byte_valid_i.
module boot_loader_controller
    import boot_loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_DEPTH = 64,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        load_req_i,
    output logic        core_reset_o,
    output logic        pm_write_o,
    output logic [31:0] pm_address_o,
    output logic [31:0] pm_data_o,
    output logic        load_done_o,
    output logic        load_error_o,
    output state_t      state_dbg
);

    localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                    state_q;
    logic [CHECKSUM_WIDTH-1:0] checksum_q;
    logic [IDX_W-1:0]          index_q;
    logic [IDX_W-1:0]          len_q;
    logic [TO_W-1:0]           timeout_q;

    logic        byte_accept;
    logic        in_frame;
    logic        timed_out;
    logic        packer_clear;
    logic        packer_strobe;
    logic [31:0] packed_word;
    logic        word_complete;

    assign byte_ready_o  = (state_q == S_IDLE) || (state_q == S_LEN) ||
                           (state_q == S_DATA) || (state_q == S_CSUM);
    assign byte_accept   = byte_valid_i && byte_ready_o;
    assign in_frame      = (state_q == S_LEN) || (state_q == S_DATA) ||
                           (state_q == S_CSUM);
    // The TIMEOUT_CYCLES-th consecutive idle cycle aborts; a byte accepted
    // in that cycle takes priority.
    assign timed_out     = in_frame && !byte_accept &&
                           (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign packer_clear  = (state_q == S_IDLE) && byte_accept &&
                           (byte_i == MAGIC_BYTE);
    assign packer_strobe = (state_q == S_DATA) && byte_accept;
    assign state_dbg     = state_q;

    byte_to_word_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (packer_clear),
        .byte_strobe   (packer_strobe),
        .byte_data     (byte_i),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            checksum_q   <= '0;
            index_q      <= '0;
            len_q        <= '0;
            timeout_q    <= '0;
            core_reset_o <= 1'b0;
            pm_write_o   <= 1'b0;
            pm_address_o <= '0;
            pm_data_o    <= '0;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
        end else begin
            pm_write_o <= 1'b0;

            if (in_frame && !byte_accept) begin
                timeout_q <= timeout_q + 1'b1;
            end else begin
                timeout_q <= '0;
            end

            if (timed_out) begin
                load_error_o <= 1'b1;
                timeout_q    <= '0;
                state_q      <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (byte_accept && (byte_i == MAGIC_BYTE)) begin
                            load_error_o <= 1'b0;
                            checksum_q   <= '0;
                            index_q      <= '0;
                            state_q      <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (byte_accept) begin
                            if ((byte_i == 8'd0) ||
                                (int'(byte_i) > PROGRAM_MEMORY_DEPTH)) begin
                                load_error_o <= 1'b1;
                                state_q      <= S_IDLE;
                            end else begin
                                len_q   <= IDX_W'(byte_i);
                                state_q <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_accept) begin
                            checksum_q <= checksum_q + byte_i;
                            if (word_complete) begin
                                pm_write_o   <= 1'b1;
                                pm_address_o <= 32'({index_q, 2'b00});
                                pm_data_o    <= packed_word;
                                state_q      <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        index_q <= index_q + 1'b1;
                        if ((index_q + 1'b1) == len_q) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_CSUM: begin
                        if (byte_accept) begin
                            if (byte_i == checksum_q) begin
                                core_reset_o <= 1'b1;
                                load_done_o  <= 1'b1;
                                state_q      <= S_RUN;
                            end else begin
                                load_error_o <= 1'b1;
                                state_q      <= S_IDLE;
                            end
                        end
                    end
                    S_RUN: begin
                        if (load_req_i) begin
                            core_reset_o <= 1'b0;
                            load_done_o  <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_controller.sv
module tb_boot_loader_controller;
    import boot_loader_pkg::*;

    localparam int DEPTH = 64;
    localparam int TMO   = 1024;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        load_req_i = 1'b0;
    logic        byte_ready_o;
    logic        core_reset_o;
    logic        pm_write_o;
    logic [31:0] pm_address_o;
    logic [31:0] pm_data_o;
    logic        load_done_o;
    logic        load_error_o;
    state_t      state_dbg;

    always #5 clk = ~clk;

    boot_loader_controller #(
        .PROGRAM_MEMORY_DEPTH (DEPTH),
        .TIMEOUT_CYCLES       (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .load_req_i   (load_req_i),
        .core_reset_o (core_reset_o),
        .pm_write_o   (pm_write_o),
        .pm_address_o (pm_address_o),
        .pm_data_o    (pm_data_o),
        .load_done_o  (load_done_o),
        .load_error_o (load_error_o),
        .state_dbg    (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected program memory writes {address, data}, in order.
    logic [63:0] exp_q[$];
    // Data bytes of the frame under test.
    logic [7:0]  data_q[$];

    // ---------------- scoreboard: every write strobe ----------------
    always @(negedge clk) begin
        if (reset && pm_write_o) begin
            logic [63:0] exp_w;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         pm_address_o, pm_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({pm_address_o, pm_data_o} !== exp_w) begin
                    n_fail++;
                    $display("FAIL pm_write: got addr %h data %h, required addr %h data %h",
                             pm_address_o, pm_data_o, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    // ---------------- model ----------------
    // Frame checksum: plain integer sum of the data bytes, mod 256.
    function automatic logic [7:0] model_csum();
        int s = 0;
        foreach (data_q[k]) s += int'(data_q[k]);
        return 8'(s % 256);
    endfunction

    // Word i lands at byte address 4*i, bytes taken least significant first.
    task automatic model_writes();
        for (int i = 0; i < data_q.size() / 4; i++) begin
            int w;
            w = int'(data_q[4*i]) + int'(data_q[4*i+1]) * 256 +
                int'(data_q[4*i+2]) * 65536 + int'(data_q[4*i+3]) * 16777216;
            exp_q.push_back({32'(i * 4), 32'(w)});
        end
    endtask

    task automatic random_data(input int n_words);
        data_q.delete();
        for (int k = 0; k < 4 * n_words; k++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // ---------------- drivers ----------------
    // Presents a byte and returns just after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = b;
        while (!byte_ready_o && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_ready_timeout: got ready %b, required 1 within 16 cycles", byte_ready_o);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_body();
        send_byte(MAGIC_BYTE);
        send_byte(8'(data_q.size() / 4));
        foreach (data_q[k]) send_byte(data_q[k]);
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        byte_valid_i = 1'b0;
        load_req_i   = 1'b1;
        @(negedge clk);
        load_req_i   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", byte_ready_o); end
        n_checks++; if (core_reset_o !== 1'b0) begin n_fail++; $display("FAIL reset_core_reset: got %b required 0", core_reset_o); end
        n_checks++; if (pm_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_pm_write: got %b required 0", pm_write_o); end
        n_checks++; if (pm_address_o !== 32'h0) begin n_fail++; $display("FAIL reset_pm_address: got %h required 0", pm_address_o); end
        n_checks++; if (pm_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_pm_data: got %h required 0", pm_data_o); end
        n_checks++; if (load_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", load_done_o); end
        n_checks++; if (load_error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b required 0", load_error_o); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", state_dbg, S_IDLE); end
        reset = 1'b1;
    endtask

    task automatic test_good_frame();
        logic [7:0] csum;
        data_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        csum = model_csum();
        model_writes();
        send_byte(MAGIC_BYTE);
        send_byte(8'h02);
        for (int k = 0; k < 4; k++) send_byte(data_q[k]);
        @(negedge clk);
        byte_valid_i = 1'b0;
        n_checks++; if (pm_write_o !== 1'b1) begin n_fail++; $display("FAIL good_write_latency: got %b required 1", pm_write_o); end
        n_checks++; if (pm_data_o !== 32'h00A00513) begin n_fail++; $display("FAIL good_word0: got %h required 00a00513", pm_data_o); end
        n_checks++; if (byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL good_write_ready: got %b required 0", byte_ready_o); end
        @(negedge clk);
        n_checks++; if (pm_write_o !== 1'b0) begin n_fail++; $display("FAIL good_write_one_cycle: got %b required 0", pm_write_o); end
        n_checks++; if (core_reset_o !== 1'b0) begin n_fail++; $display("FAIL good_core_held: got %b required 0", core_reset_o); end
        for (int k = 4; k < 8; k++) send_byte(data_q[k]);
        send_byte(csum);
        end_frame();
        n_checks++; if (core_reset_o !== 1'b1) begin n_fail++; $display("FAIL good_core_release: got %b required 1", core_reset_o); end
        n_checks++; if (load_done_o !== 1'b1) begin n_fail++; $display("FAIL good_done: got %b required 1", load_done_o); end
        n_checks++; if (byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL good_run_ready: got %b required 0", byte_ready_o); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good_writes_missing: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] csum;
        pulse_load_req();
        data_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
        csum = model_csum();
        model_writes();
        send_body();
        send_byte(csum + 8'd1);
        end_frame();
        n_checks++; if (load_error_o !== 1'b1) begin n_fail++; $display("FAIL bad_csum_error: got %b required 1", load_error_o); end
        n_checks++; if (core_reset_o !== 1'b0) begin n_fail++; $display("FAIL bad_csum_core: got %b required 0", core_reset_o); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL bad_csum_state: got %0d required %0d", state_dbg, S_IDLE); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bad_csum_writes: got %0d pending required 0", exp_q.size()); end
        model_writes();
        send_byte(MAGIC_BYTE);
        end_frame();
        n_checks++; if (load_error_o !== 1'b0) begin n_fail++; $display("FAIL error_clear_on_magic: got %b required 0", load_error_o); end
        send_byte(8'h02);
        foreach (data_q[k]) send_byte(data_q[k]);
        send_byte(csum);
        end_frame();
        n_checks++; if (core_reset_o !== 1'b1) begin n_fail++; $display("FAIL recover_core: got %b required 1", core_reset_o); end
    endtask

    task automatic test_illegal_length();
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'(DEPTH + 1);
        pulse_load_req();
        for (int i = 0; i < 2; i++) begin
            send_byte(MAGIC_BYTE);
            send_byte(lens[i]);
            end_frame();
            n_checks++; if (load_error_o !== 1'b1) begin n_fail++; $display("FAIL bad_len_error: len %h got %b required 1", lens[i], load_error_o); end
            n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL bad_len_state: len %h got %0d required %0d", lens[i], state_dbg, S_IDLE); end
            send_byte(8'h3C);
            end_frame();
            n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL bad_len_next_byte: got %0d required %0d", state_dbg, S_IDLE); end
        end
    endtask

    task automatic test_garbage_stall();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        end_frame();
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL garbage_state: got %0d required %0d", state_dbg, S_IDLE); end
        random_data(2);
        model_writes();
        send_byte(MAGIC_BYTE);
        send_byte(8'h02);
        send_byte(data_q[0]);
        send_byte(data_q[1]);
        idle_cycles(TMO - 1);
        for (int k = 2; k < 8; k++) send_byte(data_q[k]);
        send_byte(model_csum());
        end_frame();
        n_checks++; if (load_error_o !== 1'b0) begin n_fail++; $display("FAIL stall_short_error: got %b required 0", load_error_o); end
        n_checks++; if (core_reset_o !== 1'b1) begin n_fail++; $display("FAIL stall_short_core: got %b required 1", core_reset_o); end
        pulse_load_req();
        random_data(2);
        send_byte(MAGIC_BYTE);
        send_byte(8'h02);
        send_byte(data_q[0]);
        send_byte(data_q[1]);
        idle_cycles(TMO);
        @(negedge clk);
        n_checks++; if (load_error_o !== 1'b1) begin n_fail++; $display("FAIL stall_timeout_error: got %b required 1", load_error_o); end
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL stall_timeout_state: got %0d required %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_reload();
        random_data(1);
        model_writes();
        send_body();
        send_byte(model_csum());
        end_frame();
        pulse_load_req();
        n_checks++; if (core_reset_o !== 1'b0) begin n_fail++; $display("FAIL reload_core: got %b required 0", core_reset_o); end
        n_checks++; if (load_done_o !== 1'b0) begin n_fail++; $display("FAIL reload_done: got %b required 0", load_done_o); end
        n_checks++; if (byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL reload_ready: got %b required 1", byte_ready_o); end
        data_q = '{8'h6F, 8'h00, 8'h00, 8'h00};
        model_writes();
        send_body();
        send_byte(8'h6F);
        end_frame();
        n_checks++; if (core_reset_o !== 1'b1) begin n_fail++; $display("FAIL reload_release: got %b required 1", core_reset_o); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reload_writes: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        pulse_load_req();
        send_byte(MAGIC_BYTE);
        send_byte(8'h02);
        send_byte(8'h13);
        send_byte(8'h05);
        @(negedge clk);
        byte_valid_i = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d required %0d", state_dbg, S_IDLE); end
        n_checks++; if (byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", byte_ready_o); end
        n_checks++; if ({pm_address_o, pm_data_o} !== 64'h0) begin n_fail++; $display("FAIL midrst_pm: got %h required 0", {pm_address_o, pm_data_o}); end
        n_checks++; if ({core_reset_o, pm_write_o, load_done_o, load_error_o} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %b required 0000", {core_reset_o, pm_write_o, load_done_o, load_error_o}); end
        reset = 1'b1;
        random_data(3);
        model_writes();
        send_body();
        send_byte(model_csum());
        end_frame();
        n_checks++; if (core_reset_o !== 1'b1) begin n_fail++; $display("FAIL midrst_reload: got %b required 1", core_reset_o); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_writes: got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int  n;
            bit  good;
            logic [7:0] csum;
            if (core_reset_o) pulse_load_req();
            n    = $urandom_range(1, 8);
            good = ($urandom_range(0, 3) != 0);
            random_data(n);
            csum = model_csum();
            model_writes();
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                if (g == MAGIC_BYTE) g = 8'h00;
                send_byte(g);
            end
            send_body();
            send_byte(good ? csum : csum + 8'd1);
            end_frame();
            n_checks++; if (core_reset_o !== good) begin n_fail++; $display("FAIL rand_core it %0d: got %b required %b", it, core_reset_o, good); end
            n_checks++; if (load_done_o !== good) begin n_fail++; $display("FAIL rand_done it %0d: got %b required %b", it, load_done_o, good); end
            n_checks++; if (load_error_o !== !good) begin n_fail++; $display("FAIL rand_error it %0d: got %b required %b", it, load_error_o, !good); end
            n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_writes it %0d: got %0d pending required 0", it, exp_q.size()); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_illegal_length();
        test_garbage_stall();
        test_reload();
        test_reset_mid_frame();
        test_random();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
